mouse_port_ctrl: RTL

- Sits between the PS/2 mouse latch and the Z80 I/O decode.
- Accumulates signed per-packet movement into Kempston-style 8-bit position counters and button state, readable on three CPU I/O ports.
- Optionally converts the same movement into rate-limited AMX-style quadrature step outputs.
- All logic is in the clk_sys domain.

---
 rtl/pcw_mouse_pkg.sv | 28 ++
 rtl/mouse_quad_axis.sv | 58 +++++
 rtl/mouse_port_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/pcw_mouse_pkg.sv
// rtl/pcw_mouse_pkg.sv - shared types, port offsets and accumulator saturation for the mouse port
package pcw_mouse_pkg;

    typedef enum logic [1:0] {
        P0 = 2'b00,
        P1 = 2'b01,
        P2 = 2'b11,
        P3 = 2'b10
    } quad_phase_e;

    localparam logic [1:0] OFS_X   = 2'd0;
    localparam logic [1:0] OFS_Y   = 2'd1;
    localparam logic [1:0] OFS_BTN = 2'd2;

    // Symmetric clamp to +/-(2^(acc_w-1)-1); the most negative code is never produced.
    function automatic int sat_acc(input int value, input int acc_w);
        int lim;
        lim = (1 << (acc_w - 1)) - 1;
        if (value > lim) begin
            return lim;
        end
        if (value < -lim) begin
            return -lim;
        end
        return value;
    endfunction

endpackage

// File: rtl/mouse_quad_axis.sv
// rtl/mouse_quad_axis.sv - one axis of pending-step accumulator plus quadrature phase state machine
module mouse_quad_axis
    import pcw_mouse_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       strobe,
    input  logic       tick,
    input  logic [8:0] delta,
    output logic       a,
    output logic       b
);

    logic signed [ACC_W-1:0] pend_q;
    logic signed [ACC_W-1:0] pend_d;
    quad_phase_e             phase_q;
    int                      step;

    always_comb begin
        step = 0;
        if (tick && (pend_q > 0)) begin
            step = 1;
        end else if (tick && (pend_q < 0)) begin
            step = -1;
        end
        // New movement and the step taken this cycle are folded together before clamping.
        pend_d = ACC_W'(sat_acc(int'(pend_q) + (strobe ? int'($signed(delta)) : 0) - step, ACC_W));
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pend_q  <= '0;
            phase_q <= P0;
        end else begin
            pend_q <= pend_d;
            if (step > 0) begin
                case (phase_q)
                    P0:      phase_q <= P1;
                    P1:      phase_q <= P2;
                    P2:      phase_q <= P3;
                    default: phase_q <= P0;
                endcase
            end else if (step < 0) begin
                case (phase_q)
                    P0:      phase_q <= P3;
                    P3:      phase_q <= P2;
                    P2:      phase_q <= P1;
                    default: phase_q <= P0;
                endcase
            end
        end
    end

    assign {a, b} = phase_q;

endmodule

// File: rtl/mouse_port_ctrl.sv
// rtl/mouse_port_ctrl.sv - Kempston-style mouse counters on CPU I/O, optional AMX quadrature (MOUSE_QUAD_EN)
module mouse_port_ctrl
    import pcw_mouse_pkg::*;
#(
    parameter logic [7:0] BASE_PORT = 8'hD0,
    parameter int         QUAD_DIV  = 2000,
    parameter int         ACC_W     = 12
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       mouse_strobe,
    input  logic [8:0] mouse_dx,
    input  logic [8:0] mouse_dy,
    input  logic [2:0] mouse_btn,
    input  logic       io_rd,
    input  logic [7:0] io_addr,
    output logic       io_sel,
    output logic [7:0] io_dout,
    output logic       quad_xa,
    output logic       quad_xb,
    output logic       quad_ya,
    output logic       quad_yb
);

    logic [7:0] cnt_x_q;
    logic [7:0] cnt_y_q;
    logic [2:0] btn_q;
    logic [7:0] dout_q;
    logic [7:0] rd_data_d;

    assign io_sel = (io_addr[7:2] == BASE_PORT[7:2]);

    // Button byte is active-low with left/middle/right on bits 0/1/2.
    always_comb begin
        rd_data_d = 8'hFF;
        case (io_addr[1:0])
            OFS_X:   rd_data_d = cnt_x_q;
            OFS_Y:   rd_data_d = cnt_y_q;
            OFS_BTN: rd_data_d = {5'b11111, ~btn_q[1], ~btn_q[2], ~btn_q[0]};
            default: rd_data_d = 8'hFF;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_x_q <= 8'h00;
            cnt_y_q <= 8'h00;
            btn_q   <= 3'b000;
            dout_q  <= 8'hFF;
        end else begin
            if (mouse_strobe) begin
                cnt_x_q <= cnt_x_q + mouse_dx[7:0];
                cnt_y_q <= cnt_y_q + mouse_dy[7:0];
                btn_q   <= mouse_btn;
            end
            if (io_rd && io_sel) begin
                dout_q <= rd_data_d;
            end
        end
    end

    assign io_dout = dout_q;

`ifdef MOUSE_QUAD_EN
    localparam int TW = (QUAD_DIV > 2) ? $clog2(QUAD_DIV) : 1;

    logic [TW-1:0] tick_cnt_q;
    logic          tick;
    logic          unused_ok;

    assign tick = (tick_cnt_q == TW'(QUAD_DIV - 1));

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    mouse_quad_axis #(.ACC_W(ACC_W)) u_axis_x (
        .clk_sys (clk_sys),
        .reset   (reset),
        .strobe  (mouse_strobe),
        .tick    (tick),
        .delta   (mouse_dx),
        .a       (quad_xa),
        .b       (quad_xb)
    );

    mouse_quad_axis #(.ACC_W(ACC_W)) u_axis_y (
        .clk_sys (clk_sys),
        .reset   (reset),
        .strobe  (mouse_strobe),
        .tick    (tick),
        .delta   (mouse_dy),
        .a       (quad_ya),
        .b       (quad_yb)
    );

    assign unused_ok = ^{BASE_PORT[1:0]};
`else
    logic unused_ok;

    assign quad_xa   = 1'b0;
    assign quad_xb   = 1'b0;
    assign quad_ya   = 1'b0;
    assign quad_yb   = 1'b0;
    assign unused_ok = ^{BASE_PORT[1:0], mouse_dx[8], mouse_dy[8], QUAD_DIV[0], ACC_W[0]};
`endif

endmodule
